// File: rtl/hpm_types_1_13_pkg.sv
// Shared types and constants for the hardware performance monitor block.
package hpm_types_1_13_pkg;

    localparam logic [11:0] HPM_CNT_BASE       = 12'hB00;
    localparam logic [11:0] HPM_CNTH_BASE      = 12'hB80;
    localparam logic [11:0] HPM_EVT_BASE       = 12'h320;
    localparam logic [11:0] MCOUNTINHIBIT_ADDR = 12'h320;

    typedef struct packed {
        logic        of;
        logic [22:0] reserved;
        logic [7:0]  sel;
    } mhpmevent_t;

    typedef enum logic [1:0] {
        CSR_OP_NONE,
        CSR_OP_WRITE,
        CSR_OP_SET,
        CSR_OP_CLEAR
    } csr_op_e;

    // Read-modify-write result of a CSR instruction; CSR_OP_NONE leaves the value alone.
    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                              input logic [31:0] operand);
        case (op)
            CSR_OP_WRITE: csr_apply = operand;
            CSR_OP_SET:   csr_apply = old_val | operand;
            CSR_OP_CLEAR: csr_apply = old_val & ~operand;
            default:      csr_apply = old_val;
        endcase
    endfunction

endpackage

// File: rtl/priv_hpm_unit_if.sv
// CSR-side access port of the performance monitor: address, operation and read data.
interface priv_hpm_unit_if;
    logic [11:0] csr_addr;
    logic        csr_write;
    logic        csr_set;
    logic        csr_clear;
    logic        valid_write;
    logic [31:0] new_csr_val;
    logic        hpm_hit;
    logic [31:0] hpm_rdata;

    modport master (
        output csr_addr, csr_write, csr_set, csr_clear, valid_write, new_csr_val,
        input  hpm_hit, hpm_rdata
    );

    modport slave (
        input  csr_addr, csr_write, csr_set, csr_clear, valid_write, new_csr_val,
        output hpm_hit, hpm_rdata
    );
endinterface

// File: rtl/priv_hpm_counter.sv
// One HPM counter with its event selector, sticky overflow flag and own CSR decode.
module priv_hpm_counter
    import hpm_types_1_13_pkg::*;
#(
    parameter int IDX           = 3,
    parameter int NUM_EVENTS    = 8,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  inhibit,
    input  csr_op_e               op,
    input  logic [11:0]           addr,
    input  logic [31:0]           operand,
    output logic [31:0]           rdata,
    output logic                  of
);
    localparam int HI_WIDTH = COUNTER_WIDTH - 32;

    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]               sel_q, sel_d;
    logic                     of_q, of_d;
    logic                     lo_sel, hi_sel, evt_sel, op_valid, cnt_write;
    logic                     ev_hit, incr, wrap;
    logic [31:0]              lo_mod, hi_mod;
    mhpmevent_t               evt_rd;

    assign lo_sel    = (addr == HPM_CNT_BASE + 12'(IDX));
    assign hi_sel    = (addr == HPM_CNTH_BASE + 12'(IDX));
    assign evt_sel   = (addr == HPM_EVT_BASE + 12'(IDX));
    assign op_valid  = (op != CSR_OP_NONE);
    assign cnt_write = op_valid && (lo_sel || hi_sel);
    assign incr      = ev_hit && !inhibit && !cnt_write;
    assign wrap      = incr && (&cnt_q);
    assign evt_rd    = '{of: of_q, reserved: '0, sel: sel_q};
    assign lo_mod    = csr_apply(op, cnt_q[31:0], operand);
    assign hi_mod    = csr_apply(op, 32'(cnt_q[COUNTER_WIDTH-1:32]), operand);
    assign of        = of_q;

    // Pick the event line named by SEL; SEL of 0 selects nothing.
    always_comb begin
        ev_hit = 1'b0;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            if (sel_q == 8'(k + 1)) ev_hit = event_in[k];
        end
    end

    // Next state: increment first, then CSR writes override the counter halves, overflow sticks on top.
    always_comb begin
        cnt_d = cnt_q;
        sel_d = sel_q;
        of_d  = of_q;
        if (incr) cnt_d = cnt_q + COUNTER_WIDTH'(1);
        if (op_valid && lo_sel) cnt_d[31:0] = lo_mod;
        if (op_valid && hi_sel) cnt_d[COUNTER_WIDTH-1:32] = hi_mod[HI_WIDTH-1:0];
        if (op_valid && evt_sel) begin
            case (op)
                CSR_OP_WRITE: begin
                    sel_d = operand[7:0];
                    of_d  = operand[31];
                end
                CSR_OP_SET: begin
                    sel_d = sel_q | operand[7:0];
                    of_d  = of_q | operand[31];
                end
                CSR_OP_CLEAR: begin
                    sel_d = sel_q & ~operand[7:0];
                    of_d  = of_q & ~operand[31];
                end
                default: ;
            endcase
        end
        if (sel_d > 8'(NUM_EVENTS)) sel_d = '0;
        if (wrap) of_d = 1'b1;
    end

    // Counter, selector and overflow flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sel_q <= '0;
            of_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            of_q  <= of_d;
        end
    end

    // Contribute read data only when one of this counter's own CSRs is addressed.
    always_comb begin
        rdata = '0;
        if (lo_sel)       rdata = cnt_q[31:0];
        else if (hi_sel)  rdata = 32'(cnt_q[COUNTER_WIDTH-1:32]);
        else if (evt_sel) rdata = evt_rd;
    end
endmodule

// File: rtl/priv_hpm_unit.sv
// Performance monitor top: mcountinhibit, address decode, read mux and overflow interrupt.
module priv_hpm_unit
    import hpm_types_1_13_pkg::*;
#(
    parameter int NUM_COUNTERS  = 4,
    parameter int NUM_EVENTS    = 8,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NUM_EVENTS-1:0] event_in,
    priv_hpm_unit_if.slave        bus,
    output logic                  lcofi_pend
);
    localparam logic [31:0] INH_MASK = 32'(((64'd1 << NUM_COUNTERS) - 64'd1) << 3);

    csr_op_e                 op;
    logic [31:0]             inhibit_q;
    logic [31:0]             cnt_rdata [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] of_bits;
    logic [31:0]             rdata;
    logic [11:0]             addr;

    assign addr = bus.csr_addr;

    // Qualify the operation: only one-hot ops with valid_write modify state.
    always_comb begin
        op = CSR_OP_NONE;
        if (bus.valid_write) begin
            case ({bus.csr_write, bus.csr_set, bus.csr_clear})
                3'b100:  op = CSR_OP_WRITE;
                3'b010:  op = CSR_OP_SET;
                3'b001:  op = CSR_OP_CLEAR;
                default: op = CSR_OP_NONE;
            endcase
        end
    end

    // mcountinhibit keeps only the bits of implemented counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            inhibit_q <= '0;
        end else if (op != CSR_OP_NONE && addr == MCOUNTINHIBIT_ADDR) begin
            inhibit_q <= csr_apply(op, inhibit_q, bus.new_csr_val) & INH_MASK;
        end
    end

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
        priv_hpm_counter #(
            .IDX           (i + 3),
            .NUM_EVENTS    (NUM_EVENTS),
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_cnt (
            .clk      (CLK),
            .rst_n    (nRST),
            .event_in (event_in),
            .inhibit  (inhibit_q[i + 3]),
            .op       (op),
            .addr     (addr),
            .operand  (bus.new_csr_val),
            .rdata    (cnt_rdata[i]),
            .of       (of_bits[i])
        );
    end

    // Unimplemented counters contribute nothing, so their addresses read as zero.
    always_comb begin
        rdata = (addr == MCOUNTINHIBIT_ADDR) ? inhibit_q : '0;
        for (int i = 0; i < NUM_COUNTERS; i++) rdata = rdata | cnt_rdata[i];
    end

    assign bus.hpm_rdata = rdata;
    assign bus.hpm_hit   = (addr >= HPM_CNT_BASE + 12'd3  && addr <= HPM_CNT_BASE + 12'd31)
                        || (addr >= HPM_CNTH_BASE + 12'd3 && addr <= HPM_CNTH_BASE + 12'd31)
                        || (addr >= HPM_EVT_BASE + 12'd3  && addr <= HPM_EVT_BASE + 12'd31)
                        || (addr == MCOUNTINHIBIT_ADDR);

    // OF bits are flops, so the OR follows the state left by the most recent edge.
    assign lcofi_pend = |of_bits;
endmodule
